// File: rtl/led_mode_ctrl.sv
// Key-event controller: short press cycles mode, long press toggles LED enable; drives solid/blink/dim LED.
// led is registered one cycle behind mode/led_en; key pulses are always accepted (no backpressure).
module led_mode_ctrl #(
    parameter int   LONG_PRESS_TIME = 27_000_000,
    parameter int   SLOW_HALF       = 13_500_000,
    parameter int   FAST_HALF       = 3_375_000,
    parameter int   PWM_PERIOD      = 256,
    parameter int   DIM_DUTY        = 32,
    parameter logic LED_ON          = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_press,
    input  logic       flag_release,
    output logic       led,
    output logic [1:0] mode,
    output logic       led_en,
    output logic       long_press
);

    localparam int HW       = $clog2(LONG_PRESS_TIME + 1);
    localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int BW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int PW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DW       = PW + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_TIME - 1);
    localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
    localparam logic [DW-1:0] DUTY      = DW'(DIM_DUTY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [1:0]    mode_nxt;
    logic          led_en_nxt;
    logic          long_press_nxt;

    logic [BW-1:0] blink_cnt, blink_nxt;
    logic          phase, phase_nxt;
    logic [PW-1:0] pwm_cnt, pwm_nxt;
    logic          led_nxt;
    logic          restart;
    logic [BW-1:0] half_last;

    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        mode_nxt       = mode;
        led_en_nxt     = led_en;
        long_press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (flag_press && !flag_release) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                hold_nxt = hold_cnt + HW'(1);
                // Release wins over long qualification on the same edge.
                if (flag_release) begin
                    state_nxt = IDLE;
                    if (led_en) begin
                        mode_nxt = mode + 2'd1;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt      = LONG_HELD;
                    long_press_nxt = 1'b1;
                    led_en_nxt     = !led_en;
                end
            end
            LONG_HELD: begin
                if (flag_release) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        restart   = (mode_nxt != mode) || (led_en_nxt != led_en);
        half_last = (mode == 2'd2) ? FAST_LAST : SLOW_LAST;
        blink_nxt = blink_cnt;
        phase_nxt = phase;
        pwm_nxt   = pwm_cnt;
        if (restart) begin
            blink_nxt = '0;
            phase_nxt = 1'b1;
            pwm_nxt   = '0;
        end else begin
            if (mode == 2'd1 || mode == 2'd2) begin
                if (blink_cnt == half_last) begin
                    blink_nxt = '0;
                    phase_nxt = !phase;
                end else begin
                    blink_nxt = blink_cnt + BW'(1);
                end
            end
            if (mode == 2'd3) begin
                pwm_nxt = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PW'(1);
            end
        end

        led_nxt = !LED_ON;
        if (led_en) begin
            case (mode)
                2'd0:    led_nxt = LED_ON;
                2'd1,
                2'd2:    led_nxt = phase ? LED_ON : !LED_ON;
                default: led_nxt = ({1'b0, pwm_cnt} < DUTY) ? LED_ON : !LED_ON;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            mode       <= 2'd0;
            led_en     <= 1'b1;
            long_press <= 1'b0;
            led        <= !LED_ON;
            blink_cnt  <= '0;
            phase      <= 1'b1;
            pwm_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            mode       <= mode_nxt;
            led_en     <= led_en_nxt;
            long_press <= long_press_nxt;
            led        <= led_nxt;
            blink_cnt  <= blink_nxt;
            phase      <= phase_nxt;
            pwm_cnt    <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed and random key stimulus against an arithmetic reference model of led_mode_ctrl.
module tb_led_mode_ctrl;

    localparam int LPT    = 20;
    localparam int SLOW   = 8;
    localparam int FAST   = 2;
    localparam int PERIOD = 8;
    localparam int DUTY   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_press = 1'b0;
    logic       flag_release = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       led_en;
    logic       long_press;

    int checks = 0;
    int failures = 0;

    led_mode_ctrl #(
        .LONG_PRESS_TIME(LPT),
        .SLOW_HALF      (SLOW),
        .FAST_HALF      (FAST),
        .PWM_PERIOD     (PERIOD),
        .DIM_DUTY       (DUTY),
        .LED_ON         (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flag_press  (flag_press),
        .flag_release(flag_release),
        .led         (led),
        .mode        (mode),
        .led_en      (led_en),
        .long_press  (long_press)
    );

    always #5 clk = ~clk;

    // Reference model: key state as "holding since edge press_edge", pattern as time since last restart.
    int n = 0;
    int m_key = 0;          // 0 released, 1 holding, 2 holding after long press
    int press_edge = 0;
    int epoch = 0;
    int m_mode = 0;
    bit m_en = 1'b1;
    bit m_lp = 1'b0;
    bit m_led = 1'b0;

    task automatic model_edge(input bit fp, input bit fr, input bit r);
        int  k;
        int  old_mode;
        bit  old_en;
        if (r) begin
            m_led = 1'b0;
        end else begin
            k = n - epoch - 1;
            if (!m_en)            m_led = 1'b0;
            else if (m_mode == 0) m_led = 1'b1;
            else if (m_mode == 1) m_led = ((k / SLOW) % 2) == 0;
            else if (m_mode == 2) m_led = ((k / FAST) % 2) == 0;
            else                  m_led = (k % PERIOD) < DUTY;
        end
        old_mode = m_mode;
        old_en   = m_en;
        m_lp     = 1'b0;
        if (r) begin
            m_key  = 0;
            m_mode = 0;
            m_en   = 1'b1;
            epoch  = n;
        end else begin
            if (m_key == 0) begin
                if (fp && !fr) begin
                    m_key      = 1;
                    press_edge = n;
                end
            end else if (m_key == 1) begin
                if (fr) begin
                    m_key = 0;
                    if (m_en) m_mode = (m_mode + 1) % 4;
                end else if (n - press_edge == LPT) begin
                    m_key = 2;
                    m_lp  = 1'b1;
                    m_en  = !m_en;
                end
            end else begin
                if (fr) m_key = 0;
            end
            if (m_mode != old_mode || m_en != old_en) epoch = n;
        end
        n++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic step(input bit fp, input bit fr, input bit r);
        flag_press   = fp;
        flag_release = fr;
        rst          = r;
        @(posedge clk);
        model_edge(fp, fr, r);
        #1;
        chk("led", {1'b0, led}, {1'b0, m_led});
        chk("mode", mode, m_mode[1:0]);
        chk("led_en", {1'b0, led_en}, {1'b0, m_en});
        chk("long_press", {1'b0, long_press}, {1'b0, m_lp});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Press on one edge, release `hold` edges later.
    task automatic press_for(input int hold);
        step(1'b1, 1'b0, 1'b0);
        idle(hold - 1);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_led", {1'b0, led}, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("first_led", {1'b0, led}, 2'd1);

        for (int p = 0; p < 4; p++) begin
            press_for(5);
            chk("short_mode", mode, 2'((p + 1) % 4));
            idle(20);
        end

        press_for(30);
        chk("long_en_off", {1'b0, led_en}, 2'd0);
        idle(5);
        press_for(5);
        chk("dis_mode_keep", mode, 2'd0);
        idle(5);
        press_for(30);
        chk("long_en_on", {1'b0, led_en}, 2'd1);
        idle(4);

        press_for(1);
        idle(3);
        press_for(LPT);
        chk("edge_short_mode", mode, 2'd2);
        idle(12);

        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        chk("rst_mid_hold", mode, 2'd0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 11) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
